// File: rtl/gpio_pad_filter.sv
// Pad-ring GPIO conditioning: synchronises and glitch-filters inbound pads, with edge pulses.
// Outbound pad data/enables are held as inputs until a post-reset ramp window has elapsed.
module gpio_pad_filter #(
  parameter int unsigned Width        = 32,
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 4,
  parameter int unsigned RampCycles   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] pad_din_i,
  input  logic [Width-1:0] filt_en_i,
  output logic [Width-1:0] gpio_i_o,
  output logic [Width-1:0] edge_rise_o,
  output logic [Width-1:0] edge_fall_o,
  input  logic [Width-1:0] gpio_o_i,
  input  logic [Width-1:0] gpio_en_i,
  output logic [Width-1:0] pad_dout_o,
  output logic [Width-1:0] pad_oen_o,
  output logic [Width-1:0] pad_ie_o,
  output logic             ramp_done_o
);

  localparam int unsigned CntW  = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
  localparam int unsigned RampW = $clog2(RampCycles + 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(FilterCycles - 1);
  localparam logic [RampW-1:0] RampEnd = RampW'(RampCycles);

  logic [SyncStages-1:0][Width-1:0] sync_q, sync_d;
  logic [Width-1:0][CntW-1:0]       cnt_q, cnt_d;
  logic [Width-1:0]                 s;
  logic [Width-1:0]                 f_q, f_d;
  logic [Width-1:0]                 rise_q, rise_d;
  logic [Width-1:0]                 fall_q, fall_d;
  logic [RampW-1:0]                 ramp_cnt_q, ramp_cnt_d;
  logic                             ramp_done_q, ramp_done_d;
  logic [Width-1:0]                 dout_q, dout_d;
  logic [Width-1:0]                 oen_q, oen_d;

  // Shift chain: stage 0 captures the raw pad, the last stage feeds the filter.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], pad_din_i};
    s      = sync_q[SyncStages-1];
  end

  // Per-bit stability filter; a bypassed bit follows s directly with its counter cleared.
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int b = 0; b < Width; b++) begin
      if (!filt_en_i[b] || (s[b] == f_q[b])) begin
        f_d[b]   = s[b];
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CntMax) begin
        f_d[b]   = s[b];
        cnt_d[b] = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CntW'(1);
      end
    end
    rise_d = f_d & ~f_q;
    fall_d = ~f_d & f_q;
  end

  // Ramp counter saturates at RampCycles; done is looked ahead so it rises with the count.
  always_comb begin
    ramp_cnt_d  = (ramp_cnt_q == RampEnd) ? ramp_cnt_q : ramp_cnt_q + RampW'(1);
    ramp_done_d = ramp_done_q | (ramp_cnt_d == RampEnd);
    dout_d      = ramp_done_q ? gpio_o_i : '0;
    oen_d       = ramp_done_q ? ~gpio_en_i : '1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      f_q         <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      ramp_cnt_q  <= '0;
      ramp_done_q <= 1'b0;
      dout_q      <= '0;
      oen_q       <= '1;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      f_q         <= f_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      ramp_cnt_q  <= ramp_cnt_d;
      ramp_done_q <= ramp_done_d;
      dout_q      <= dout_d;
      oen_q       <= oen_d;
    end
  end

  assign gpio_i_o    = f_q;
  assign edge_rise_o = rise_q;
  assign edge_fall_o = fall_q;
  assign pad_dout_o  = dout_q;
  assign pad_oen_o   = oen_q;
  assign pad_ie_o    = ~oen_q;
  assign ramp_done_o = ramp_done_q;

endmodule

// File: tb/tb_gpio_pad_filter.sv
// Bench for gpio_pad_filter: history-based reference model feeds a scoreboard queue,
// a negedge monitor pops and compares every output each cycle.
module tb_gpio_pad_filter;

  localparam int W    = 32;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int RAMP = 16;
  localparam int MAXC = 4096;

  typedef struct packed {
    logic [W-1:0] gpio;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] dout;
    logic [W-1:0] oen;
    logic [W-1:0] ie;
    logic         ramp;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [W-1:0] pad_din_i, filt_en_i, gpio_o_i, gpio_en_i;
  logic [W-1:0] gpio_i_o, edge_rise_o, edge_fall_o, pad_dout_o, pad_oen_o, pad_ie_o;
  logic         ramp_done_o;

  gpio_pad_filter #(
    .Width(W), .SyncStages(SYNC), .FilterCycles(FILT), .RampCycles(RAMP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pad_din_i(pad_din_i), .filt_en_i(filt_en_i),
    .gpio_i_o(gpio_i_o), .edge_rise_o(edge_rise_o), .edge_fall_o(edge_fall_o),
    .gpio_o_i(gpio_o_i), .gpio_en_i(gpio_en_i), .pad_dout_o(pad_dout_o),
    .pad_oen_o(pad_oen_o), .pad_ie_o(pad_ie_o), .ramp_done_o(ramp_done_o)
  );

  always #5 clk_i = ~clk_i;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           k = 0;
  logic         in_rst = 1'b1;
  logic [W-1:0] pad_h [MAXC];
  logic [W-1:0] filt_h[MAXC];
  logic [W-1:0] go_h  [MAXC];
  logic [W-1:0] ge_h  [MAXC];
  logic [W-1:0] f_h   [MAXC];

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, k, act, exp);
    end
  endfunction

  // Value presented at the last synchroniser stage during cycle j.
  function automatic logic [W-1:0] s_at(input int j);
    return (j >= SYNC) ? pad_h[j-SYNC] : '0;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e      = '0;
    e.oen  = '1;
    e.ie   = '0;
    return e;
  endfunction

  // Assert reset right after an edge so the monitor sees it without any intervening clock.
  task automatic reset_for(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      in_rst = 1'b1;
      sb.push_back(reset_exp());
    end
  endtask

  // One cycle: predict this cycle's outputs from input history, then apply new inputs.
  task automatic cycle(input logic [W-1:0] pad, input logic [W-1:0] filt,
                       input logic [W-1:0] go, input logic [W-1:0] ge);
    exp_t         e;
    logic [W-1:0] fk, sv, sj, fp, fj, fe;
    logic         ok;
    @(posedge clk_i); #1;
    if (in_rst) begin
      rst_ni = 1'b1;
      in_rst = 1'b0;
      k      = 0;
    end else begin
      k = k + 1;
    end
    if (k >= MAXC) begin
      $display("FAIL history_overflow cycle=%0d limit=%0d", k, MAXC);
      $fatal(1);
    end
    if (k == 0) begin
      fk = '0;
      fp = '0;
    end else begin
      fp = f_h[k-1];
      fk = fp;
      sv = s_at(k-1);
      fe = filt_h[k-1];
      for (int b = 0; b < W; b++) begin
        if (!fe[b]) begin
          fk[b] = sv[b];
        end else if (k >= FILT) begin
          // Accept only after FILT consecutive filtered edges disagreeing with an unchanged value.
          ok = 1'b1;
          for (int j = k - FILT + 1; j <= k; j++) begin
            sj = s_at(j-1);
            fj = f_h[j-1];
            fe = filt_h[j-1];
            if (!fe[b] || (sj[b] == fp[b]) || (fj[b] != fp[b])) ok = 1'b0;
          end
          if (ok) fk[b] = ~fp[b];
        end
      end
    end
    f_h[k] = fk;
    e.gpio = fk;
    e.rise = fk & ~fp;
    e.fall = ~fk & fp;
    e.ramp = (k >= RAMP);
    if (k >= RAMP + 1) begin
      e.dout = go_h[k-1];
      e.oen  = ~ge_h[k-1];
    end else begin
      e.dout = '0;
      e.oen  = '1;
    end
    e.ie = ~e.oen;
    sb.push_back(e);
    pad_din_i = pad;  filt_en_i = filt;  gpio_o_i = go;  gpio_en_i = ge;
    pad_h[k]  = pad;  filt_h[k] = filt;  go_h[k]  = go;  ge_h[k]  = ge;
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gpio_i_o",    gpio_i_o,    e.gpio);
        chk("edge_rise_o", edge_rise_o, e.rise);
        chk("edge_fall_o", edge_fall_o, e.fall);
        chk("pad_dout_o",  pad_dout_o,  e.dout);
        chk("pad_oen_o",   pad_oen_o,   e.oen);
        chk("pad_ie_o",    pad_ie_o,    e.ie);
        chk("ramp_done_o", W'(ramp_done_o), W'(e.ramp));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d expected completion before timeout", k);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] pad, filt;
    rst_ni = 1'b0;
    pad_din_i = '0; filt_en_i = '0; gpio_o_i = '0; gpio_en_i = '0;
    reset_for(3);

    // Ramp window with outputs requested from the start.
    repeat (22) cycle('0, '0, 32'hA5A5A5A5, '1);

    // Bit0 filtered rise held; bit1 filtered 3-cycle glitch; bit2 bypassed 1-cycle pulse.
    repeat (10) cycle(32'h1, 32'h3, 32'h1234_5678, 32'h0F0F_0F0F);
    repeat (3)  cycle(32'h3, 32'h3, 32'h1234_5678, 32'h0F0F_0F0F);
    repeat (10) cycle(32'h1, 32'h3, 32'h1234_5678, 32'h0F0F_0F0F);
    cycle(32'h5, 32'h3, 32'h0, '1);
    repeat (8)  cycle(32'h1, 32'h3, 32'h0, '1);

    // Bit3 filtered count in flight when reset hits; ramp must repeat.
    repeat (5)  cycle(32'h9, 32'h8, 32'hFFFF_FFFF, '1);
    reset_for(2);
    repeat (22) cycle(32'h9, 32'h8, 32'hFFFF_FFFF, '1);

    // All bits toggled together, upper half filtered.
    repeat (10) cycle('1, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'hFFFF_0000);
    repeat (10) cycle('0, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'hFFFF_0000);

    // Filter enable toggled mid-count on bit4.
    repeat (3)  cycle(32'h10, 32'h10, '0, '0);
    repeat (6)  cycle(32'h10, 32'h00, '0, '0);
    repeat (3)  cycle(32'h00, 32'h10, '0, '0);
    repeat (2)  cycle(32'h00, 32'h00, '0, '0);
    repeat (8)  cycle(32'h00, 32'h10, '0, '0);

    // Randomised segments with sparse toggles so both glitches and accepted changes occur.
    pad = '0;
    for (int seg = 0; seg < 6; seg++) begin
      filt = $urandom;
      if (seg == 3) reset_for(1 + int'($urandom_range(2)));
      for (int i = 0; i < 120; i++) begin
        pad = pad ^ ($urandom & $urandom & $urandom);
        if ($urandom_range(39) == 0) filt = filt ^ $urandom;
        cycle(pad, filt, $urandom, $urandom);
      end
    end

    @(negedge clk_i); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_pad_filter.md
Name: gpio_pad_filter

Overview:
- Sits between the zerosoc GPIO ports and the pad-ring signal bundle inside the chip top. Replaces the direct pad-to-core GPIO wiring.
- Inbound: synchronises raw pad inputs, applies an optional per-bit glitch filter and produces edge pulses.
- Outbound: registers core output data and enables into pad dout/oen/ie. Holds all pads as inputs during a post-reset ramp window.

Parameters:
- Width, 32, number of GPIO bits.
- SyncStages, 2, synchroniser depth (>=2).
- FilterCycles, 4, consecutive stable cycles needed to accept a change (>=1).
- RampCycles, 16, cycles after reset release during which pads are forced to input (>=1).

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- pad_din_i  input  Width  raw pad input data.
- filt_en_i  input  Width  per-bit filter enable (0 = bypass).
- gpio_i_o  output  Width  conditioned input to core gpio_i.
- edge_rise_o  output  Width  one-cycle pulse on 0->1 of gpio_i_o.
- edge_fall_o  output  Width  one-cycle pulse on 1->0 of gpio_i_o.
- gpio_o_i  input  Width  core output data.
- gpio_en_i  input  Width  core output enable (active-high).
- pad_dout_o  output  Width  pad output data.
- pad_oen_o  output  Width  pad output enable (active-low).
- pad_ie_o  output  Width  pad input-enable pin, equals ~pad_oen_o (pad pin is really active-low ien).
- ramp_done_o  output  1  high once the ramp window has elapsed.

Behaviour:
- Reset values: all synchroniser flops 0, filter counters 0, gpio_i_o 0, edges 0, pad_dout_o 0, pad_oen_o all 1, pad_ie_o all 0, ramp_done_o 0, ramp counter 0.
- Synchroniser: per bit, SyncStages flops in series; s = last stage.
- Filter, per bit with filt_en=1, evaluated on each clock edge:
  - if s==f: cnt<=0.
  - else if cnt==FilterCycles-1: f<=s, cnt<=0.
  - else: cnt<=cnt+1.
- Filter timing:
  - A change on s must persist FilterCycles consecutive cycles to reach f.
  - Pad-to-gpio_i_o latency is SyncStages+FilterCycles cycles.
  - A pulse shorter than FilterCycles cycles at s never reaches f; its counter clears when s returns to f.
- Counter width is clog2(FilterCycles), minimum 1 bit; the counter never exceeds FilterCycles-1.
- Bypass (filt_en=0): f<=s every cycle and cnt<=0. Latency is SyncStages+1.
  - Toggling filt_en mid-count: falling to 0 takes s on the next edge; rising to 1 starts the counter from 0.
- gpio_i_o = f, registered.
- Edge outputs:
  - edge_rise_o registered as (f_next & ~f); edge_fall_o registered as (~f_next & f).
  - Each pulse is high exactly in the first cycle gpio_i_o shows the new value.
  - Never both high on the same bit.
- Ramp:
  - The counter starts at 0 on reset release and increments each cycle until it equals RampCycles, then holds.
  - ramp_done_o = (counter==RampCycles), registered and sticky until reset.
- Output path while ramp_done_o=0: pad_oen_o all 1, pad_dout_o 0, gpio_o_i/gpio_en_i ignored.
- Output path while ramp_done_o=1, registered with 1-cycle latency from the core ports: pad_dout_o<=gpio_o_i, pad_oen_o<=~gpio_en_i.
  - The first cycle with ramp_done_o=1 still shows the forced ramp values; core values appear on the following cycle.
- pad_ie_o = ~pad_oen_o at all times, combinational from the oen register.
- Reset asserted mid-operation: all state returns to reset values immediately; the ramp restarts on release. In-flight filter counts are discarded.
- No dependency between bits; all Width bits are evaluated in parallel every cycle.

Test Plan:
- Reset release, gpio_en_i=all 1, gpio_o_i=0xA5A5A5A5 -> pad_oen_o=all 1 and pad_dout_o=0 for cycles 0..16; ramp_done_o rises at cycle 16; pad_dout_o=0xA5A5A5A5 and pad_oen_o=0 from cycle 17; pad_ie_o=~pad_oen_o throughout.
- Bit0 filter on, pad_din_i[0] 0->1 held -> gpio_i_o[0]=1 and a single edge_rise_o[0] pulse exactly 6 cycles later (2 sync + 4 filter).
- Bit1 filter on, 3-cycle high glitch on pad_din_i[1] -> gpio_i_o[1] stays 0, no edge pulses; counter returns to 0.
- Bit2 filter off, 1-cycle pulse that straddles a clock edge so it is captured -> gpio_i_o[2] high for 1 cycle at latency 3, with edge_rise_o then edge_fall_o pulses.
- Filtered count in progress on bit3 (cnt=2) and rst_ni pulsed low -> gpio_i_o, edges and ramp_done_o go to 0 asynchronously; the ramp repeats its 16 forced cycles after release.
- All 32 bits toggled simultaneously with filt_en_i=0xFFFF0000 -> bits 31:16 update at latency 6, bits 15:0 at latency 3; edge pulses per bit match.
